// File: rtl/lockin_demod_if.sv
// lockin_demod_if
// Result port of the lock-in demodulator: a valid/ready channel carrying the
// in-phase and quadrature sums, plus the sticky overrun flag.
//
//   i_out     signed in-phase sum            (master -> slave)
//   q_out     signed quadrature sum          (master -> slave)
//   out_valid i_out/q_out hold a fresh result (master -> slave)
//   overrun   a dump was dropped while full   (master -> slave)
//   out_ready consumer accepts the result     (slave -> master)
interface lockin_demod_if #(
   parameter int ACC_W = 27
);
   logic signed [ACC_W-1:0] i_out;
   logic signed [ACC_W-1:0] q_out;
   logic                    out_valid;
   logic                    out_ready;
   logic                    overrun;

   modport master (
      output i_out,
      output q_out,
      output out_valid,
      output overrun,
      input  out_ready
   );

   modport slave (
      input  i_out,
      input  q_out,
      input  out_valid,
      input  overrun,
      output out_ready
   );
endinterface

// File: rtl/lockin_demod.sv
// lockin_demod
// Lock-in demodulator stage. Each sampled cycle the 1-bit comparator input
// (+1/-1) multiplies the DDS sine/cosine references; the products are summed
// over 2^DECIM_LOG2 samples and the I/Q sums are handed downstream through a
// valid/ready port.
//
//   clk   system clock
//   rst   asynchronous, active-low reset
//   en    sample strobe, one sample per cycle with en=1
//   v     comparator input, 1 = +1, 0 = -1
//   sin   signed DDS sine reference
//   cos   signed DDS cosine reference
//   clr   synchronous clear of all accumulation state
//   out   result port (i_out, q_out, out_valid, out_ready, overrun)
module lockin_demod #(
   parameter int DECIM_LOG2 = 10,
   parameter int ACC_W      = 17 + DECIM_LOG2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                v,
   input  logic signed [15:0]  sin,
   input  logic signed [15:0]  cos,
   input  logic                clr,
   lockin_demod_if.master      out
);

   logic signed [16:0]       sin_ext;
   logic signed [16:0]       cos_ext;
   logic signed [16:0]       term_i;
   logic signed [16:0]       term_q;
   logic                     tvalid;

   logic signed [ACC_W-1:0]  acc_i;
   logic signed [ACC_W-1:0]  acc_q;
   logic [DECIM_LOG2-1:0]    cnt;

   logic signed [ACC_W-1:0]  term_i_ext;
   logic signed [ACC_W-1:0]  term_q_ext;
   logic signed [ACC_W-1:0]  sum_i;
   logic signed [ACC_W-1:0]  sum_q;
   logic                     last_sample;
   logic                     dump;
   logic                     slot_free;

   // Widening to 17 bits before negating keeps -(-32768) exact.
   assign sin_ext = {sin[15], sin};
   assign cos_ext = {cos[15], cos};

   assign term_i_ext = {{DECIM_LOG2{term_i[16]}}, term_i};
   assign term_q_ext = {{DECIM_LOG2{term_q[16]}}, term_q};

   // The dump result includes the term arriving in the same cycle, so the
   // accumulator can restart at zero without losing the next block's first
   // sample.
   assign sum_i       = acc_i + term_i_ext;
   assign sum_q       = acc_q + term_q_ext;
   assign last_sample = (cnt == {DECIM_LOG2{1'b1}});
   assign dump        = tvalid && last_sample;
   assign slot_free   = !out.out_valid || out.out_ready;

   // Stage 1: register the signed +/- reference terms for each sample.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         term_i <= '0;
         term_q <= '0;
         tvalid <= 1'b0;
      end else if (clr) begin
         term_i <= '0;
         term_q <= '0;
         tvalid <= 1'b0;
      end else if (en) begin
         term_i <= v ? sin_ext : -sin_ext;
         term_q <= v ? cos_ext : -cos_ext;
         tvalid <= 1'b1;
      end else begin
         tvalid <= 1'b0;
      end
   end

   // Stage 2: accumulate registered terms; cnt counts samples, not cycles,
   // so gaps in en just pause the block.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc_i <= '0;
         acc_q <= '0;
         cnt   <= '0;
      end else if (clr) begin
         acc_i <= '0;
         acc_q <= '0;
         cnt   <= '0;
      end else if (tvalid) begin
         if (last_sample) begin
            acc_i <= '0;
            acc_q <= '0;
         end else begin
            acc_i <= sum_i;
            acc_q <= sum_q;
         end
         cnt <= cnt + 1'b1;
      end
   end

   // Output slot: a dump loads only if the slot is empty or being consumed
   // this cycle; otherwise the result is dropped and overrun sticks until clr.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out.i_out     <= '0;
         out.q_out     <= '0;
         out.out_valid <= 1'b0;
         out.overrun   <= 1'b0;
      end else if (clr) begin
         out.out_valid <= 1'b0;
         out.overrun   <= 1'b0;
      end else if (dump) begin
         if (slot_free) begin
            out.i_out     <= sum_i;
            out.q_out     <= sum_q;
            out.out_valid <= 1'b1;
         end else begin
            out.overrun   <= 1'b1;
         end
      end else if (out.out_valid && out.out_ready) begin
         out.out_valid <= 1'b0;
      end
   end

endmodule

// File: doc/lockin_demod.md
# lockin_demod

Lock-in demodulator stage fed by the DDS core. Each sample-enabled cycle it multiplies the 1-bit comparator input `v` (±1) by the DDS `sin`/`cos` references and accumulates. It dumps in-phase/quadrature sums every 2^DECIM_LOG2 samples through a valid/ready output port toward the downstream filter/readout logic.

## Interface
- DECIM_LOG2, 10, log2 of samples per dump; legal range 1..16
- ACC_W, 17+DECIM_LOG2, accumulator/output width (derived; must not be overridden)
- clk  input  1  system clock (PLL clock domain)
- rst  input  1  reset; asynchronous, active-low
- en  input  1  sample strobe; one sample taken per cycle with en=1
- v  input  1  comparator input; 1 means +1, 0 means −1
- sin  input  16  signed DDS sine reference
- cos  input  16  signed DDS cosine reference
- clr  input  1  synchronous clear of all accumulation state
- i_out  output  ACC_W  signed in-phase sum
- q_out  output  ACC_W  signed quadrature sum
- out_valid  output  1  i_out/q_out hold an unconsumed result
- out_ready  input  1  consumer accepts the result when out_valid=1 and out_ready=1
- overrun  output  1  sticky: a dump was dropped because the output was still occupied

## Operation
- Stage 1 (term register): on en=1, sin and cos are sign-extended to 17 bits. term_i = v ? sin : −sin, and term_q = v ? cos : −cos. tvalid<=1. On en=0, tvalid<=0.
- Negation is done at 17 bits: −(−32768) = +32768 is exact. Terms are sign-extended to ACC_W.
- Stage 2 (accumulate): on tvalid=1 with cnt != 2^DECIM_LOG2−1: acc_i += term_i, acc_q += term_q, cnt++.
- Dump: on tvalid=1 with cnt == 2^DECIM_LOG2−1, the final sums are acc_i+term_i and acc_q+term_q. acc_i and acc_q reset to 0, and cnt wraps to 0.
  - If the output slot is free (out_valid=0, or out_ready=1 this cycle), the sums load into i_out/q_out and out_valid<=1.
  - Otherwise the new result is discarded, i_out/q_out stay unchanged, and overrun<=1.
- Handshake: out_valid=1 with out_ready=1 consumes the result. If no dump occurs that cycle, out_valid<=0. A dump in the same cycle as consumption loads new data and out_valid stays 1.
- Overflow is impossible by construction: |sum| ≤ 2^DECIM_LOG2·32768 < 2^(ACC_W−1).
- clr=1:
  - Zeroes acc_i, acc_q, cnt, tvalid and the stage-1 terms.
  - Drops out_valid to 0 and clears overrun.
  - i_out/q_out keep their values.
  - clr overrides en, a dump and a handshake in the same cycle; any en sample that cycle is lost.
- rst=0 (asynchronous, any time, including mid-dump):
  - All registers go to 0: i_out=0, q_out=0, out_valid=0, overrun=0, acc=0, cnt=0, tvalid=0.
  - Operation resumes on the first rising clk edge after rst deasserts, with a fresh count of 2^DECIM_LOG2 samples.

## Timing
- Sample on cycle n (en=1): term registered at edge n+1, accumulated at edge n+2.
- Latency: last sample of a block at cycle n gives out_valid=1 and valid data visible after edge n+2.
- Throughput: en may be high every cycle. A dump and the first sample of the next block accumulate back-to-back without a lost sample.
- out_valid deasserts at the edge following the handshake cycle. The result may be consumed in the first cycle out_valid is seen high.
- en gaps of any length only pause accumulation; cnt counts samples, not cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Basic sum, DECIM_LOG2=2: rst, then v=1, sin=1000, cos=−2000, en=1 for 4 cycles, out_ready=1 → 2 cycles after the 4th sample, out_valid=1 for one cycle with i_out=4000 and q_out=−8000.
- Negative full-scale, DECIM_LOG2=2: v=0, sin=−32768, cos=32767, en for 4 cycles → i_out=131072, q_out=−131068, no wrap.
- Back-to-back blocks with gaps, DECIM_LOG2=2: 8 samples alternating v=1/0 with sin=500, en toggling 1,0 → two results, each i_out=0, with exactly 4 samples per dump.
- Backpressure, DECIM_LOG2=2: out_ready=0 across two full blocks with sums 4000 then 8000 → i_out holds 4000 and overrun=1. Asserting out_ready consumes 4000, out_valid→0, and overrun stays 1 until clr.
- clr collision: assert clr together with en after 2 of 4 samples → out_valid=0, overrun=0. The next 4 samples of sin=100, v=1 give i_out=400, with no contribution from pre-clr samples or the colliding sample.
- Async reset mid-block: drop rst for a half cycle after 3 samples with out_valid=1 → all outputs 0 immediately. The next 4 samples give a correct fresh sum.
